// File: rtl/abc.sv
// Acquisition-and-reduce controller: starts three A/D converters together, waits
// for all of them, latches the unsigned minimum and offers it over a dav_/rfd handshake.
module abc (
  input  logic       clock,
  input  logic       reset_,
  output logic       soc,
  input  logic       eoc1,
  input  logic       eoc2,
  input  logic       eoc3,
  input  logic [7:0] x1,
  input  logic [7:0] x2,
  input  logic [7:0] x3,
  output logic       dav_,
  input  logic       rfd,
  output logic [7:0] min
);

  typedef enum logic [1:0] {
    S0 = 2'd0,  // start: soc held high until every converter reports busy
    S1 = 2'd1,  // wait until every converter reports done
    S2 = 2'd2,  // offer: dav_ held low until the consumer acknowledges
    S3 = 2'd3   // wait for the consumer to be ready again
  } star_t;

  star_t      star, star_nxt;
  logic       soc_r, soc_nxt;
  logic       dav_r, dav_nxt;
  logic [7:0] min_r, min_nxt;
  logic [7:0] min12, min123;
  logic       all_busy, all_done;

  // Two-stage unsigned compare; ties fall through to the shared value.
  assign min12  = (x1 < x2)    ? x1    : x2;
  assign min123 = (min12 < x3) ? min12 : x3;

  assign all_busy = ~eoc1 & ~eoc2 & ~eoc3;
  assign all_done =  eoc1 &  eoc2 &  eoc3;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      star  <= S3;
      soc_r <= 1'b0;
      dav_r <= 1'b1;
      min_r <= 8'd0;
    end else begin
      star  <= star_nxt;
      soc_r <= soc_nxt;
      dav_r <= dav_nxt;
      min_r <= min_nxt;
    end
  end

  // NOTE: every output of this block gets a default first (hold the current
  // value), so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    star_nxt = star;
    soc_nxt  = soc_r;
    dav_nxt  = dav_r;
    min_nxt  = min_r;
    unique case (star)
      S3: begin
        if (rfd) begin
          soc_nxt  = 1'b1;
          star_nxt = S0;
        end
      end
      S0: begin
        if (all_busy) begin
          soc_nxt  = 1'b0;
          star_nxt = S1;
        end
      end
      S1: begin
        // x inputs matter only on this exit edge.
        if (all_done) begin
          min_nxt  = min123;
          dav_nxt  = 1'b0;
          star_nxt = S2;
        end
      end
      S2: begin
        if (!rfd) begin
          dav_nxt  = 1'b1;
          star_nxt = S3;
        end
      end
      default: star_nxt = S3;
    endcase
  end

  assign soc  = soc_r;
  assign dav_ = dav_r;
  assign min  = min_r;

endmodule

// File: tb/tb_abc.sv
// Self-checking bench for abc: table-driven rounds, shuffled and random rounds
// against a reference minimum, plus handshake-hold and mid-round reset sequences.
module tb_abc;

  logic       clock = 1'b0;
  logic       reset_;
  logic       soc;
  logic       eoc1, eoc2, eoc3;
  logic [7:0] x1, x2, x3;
  logic       dav_;
  logic       rfd;
  logic [7:0] min;

  int errors = 0;
  int checks = 0;

  abc dut (
    .clock (clock),
    .reset_(reset_),
    .soc   (soc),
    .eoc1  (eoc1),
    .eoc2  (eoc2),
    .eoc3  (eoc3),
    .x1    (x1),
    .x2    (x2),
    .x3    (x3),
    .dav_  (dav_),
    .rfd   (rfd),
    .min   (min)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] a, b, c;
    int         d1, d2, d3;
    int         hold;
    logic [7:0] exp_min;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge; inputs change there too.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Reference: smallest of the three samples, found by a plain scan.
  function automatic logic [7:0] ref_min(input logic [7:0] a, b, c);
    logic [7:0] v [3];
    logic [7:0] m;
    v[0] = a; v[1] = b; v[2] = c;
    m = 8'd255;
    foreach (v[i]) if (v[i] < m) m = v[i];
    return m;
  endfunction

  // Drives one complete round starting from S3/S0 with rfd high.
  task automatic do_round(input logic [7:0] a, b, c, input int d1, d2, d3,
                          input int hold, input logic [7:0] exp, input string name);
    int maxd;
    int budget;
    budget = 0;
    while (soc !== 1'b1 && budget < 5) begin
      step();
      budget++;
    end
    check({name, " soc_start"}, soc, 1'b1);
    // A partial busy indication must keep soc asserted.
    eoc1 = 1'b0;
    step();
    check({name, " soc_partial"}, soc, 1'b1);
    eoc2 = 1'b0; eoc3 = 1'b0;
    step();
    check({name, " soc_fall"}, soc, 1'b0);
    x1 = a; x2 = b; x3 = c;
    maxd = d1;
    if (d2 > maxd) maxd = d2;
    if (d3 > maxd) maxd = d3;
    for (int cyc = 1; cyc <= maxd; cyc++) begin
      eoc1 = (cyc >= d1);
      eoc2 = (cyc >= d2);
      eoc3 = (cyc >= d3);
      step();
      if (cyc < maxd) check({name, " dav_wait"}, dav_, 1'b1);
    end
    check({name, " dav_fall"}, dav_, 1'b0);
    check({name, " min"}, min, exp);
    // Results must not be re-sampled after the exit edge.
    x1 = 8'($urandom); x2 = 8'($urandom); x3 = 8'($urandom);
    for (int h = 0; h < hold; h++) begin
      step();
      check({name, " hold_dav"}, dav_, 1'b0);
      check({name, " hold_min"}, min, exp);
      check({name, " hold_soc"}, soc, 1'b0);
    end
    rfd = 1'b0;
    step();
    check({name, " dav_rise"}, dav_, 1'b1);
    step();
    check({name, " soc_idle"}, soc, 1'b0);
    rfd = 1'b1;
    step();
    check({name, " soc_again"}, soc, 1'b1);
  endtask

  task automatic apply_reset_check(input string name);
    reset_ = 1'b0;
    #1;
    check({name, " rst_soc"}, soc, 1'b0);
    check({name, " rst_dav"}, dav_, 1'b1);
    check({name, " rst_min"}, min, 8'd0);
    eoc1 = 1'b1; eoc2 = 1'b1; eoc3 = 1'b1;
    rfd = 1'b1;
    step();
    reset_ = 1'b1;
    step();
    check({name, " soc_after_rst"}, soc, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [6];
    logic [7:0] v [3];
    logic [7:0] base;
    int rot;

    vecs[0] = '{a:8'd10,  b:8'd20,  c:8'd30,  d1:1, d2:2, d3:3, hold:10, exp_min:8'd10};
    vecs[1] = '{a:8'd20,  b:8'd30,  c:8'd10,  d1:3, d2:1, d3:2, hold:0,  exp_min:8'd10};
    vecs[2] = '{a:8'd30,  b:8'd10,  c:8'd20,  d1:2, d2:3, d3:1, hold:1,  exp_min:8'd10};
    vecs[3] = '{a:8'd0,   b:8'd255, c:8'd128, d1:1, d2:1, d3:1, hold:0,  exp_min:8'd0};
    vecs[4] = '{a:8'd255, b:8'd255, c:8'd255, d1:2, d2:2, d3:2, hold:2,  exp_min:8'd255};
    vecs[5] = '{a:8'd7,   b:8'd7,   c:8'd9,   d1:4, d2:1, d3:1, hold:0,  exp_min:8'd7};

    reset_ = 1'b0;
    rfd = 1'b1;
    eoc1 = 1'b1; eoc2 = 1'b1; eoc3 = 1'b1;
    x1 = '0; x2 = '0; x3 = '0;
    #1;
    step();
    step();
    check("reset soc", soc, 1'b0);
    check("reset dav", dav_, 1'b1);
    check("reset min", min, 8'd0);
    reset_ = 1'b1;
    step();
    check("soc one clock after release", soc, 1'b1);

    foreach (vecs[i])
      do_round(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d1, vecs[i].d2, vecs[i].d3,
               vecs[i].hold, vecs[i].exp_min, $sformatf("vec%0d", i));

    // Sixteen rounds: base, 2*base, 3*base in a rotating order.
    for (int r = 0; r < 16; r++) begin
      base = 8'(10 + r);
      rot = r % 3;
      v[rot] = base;
      v[(rot + 1) % 3] = 8'(base * 2);
      v[(rot + 2) % 3] = 8'(base * 3);
      if (r % 2 == 1) begin
        v[0] = v[0] ^ v[1]; v[1] = v[0] ^ v[1]; v[0] = v[0] ^ v[1];
      end
      do_round(v[0], v[1], v[2], 1 + (r % 3), 1 + ((r + 1) % 3), 1 + ((r + 2) % 4),
               0, base, $sformatf("base%0d", r));
    end

    for (int r = 0; r < 10; r++) begin
      v[0] = 8'($urandom); v[1] = 8'($urandom); v[2] = 8'($urandom);
      do_round(v[0], v[1], v[2], $urandom_range(1, 4), $urandom_range(1, 4),
               $urandom_range(1, 4), $urandom_range(0, 3),
               ref_min(v[0], v[1], v[2]), $sformatf("rand%0d", r));
    end

    // Reset while waiting for results (S1).
    step();
    eoc1 = 1'b0; eoc2 = 1'b0; eoc3 = 1'b0;
    step();
    check("s1 entry soc", soc, 1'b0);
    eoc1 = 1'b1;
    x1 = 8'd3; x2 = 8'd4; x3 = 8'd5;
    apply_reset_check("rst_s1");
    do_round(8'd44, 8'd40, 8'd41, 1, 2, 1, 0, 8'd40, "after_rst_s1");

    // Reset while offering data (S2).
    eoc1 = 1'b0; eoc2 = 1'b0; eoc3 = 1'b0;
    step();
    x1 = 8'd90; x2 = 8'd91; x3 = 8'd92;
    eoc1 = 1'b1; eoc2 = 1'b1; eoc3 = 1'b1;
    step();
    check("s2 entry dav", dav_, 1'b0);
    check("s2 entry min", min, 8'd90);
    rfd = 1'b0;
    apply_reset_check("rst_s2");
    do_round(8'd200, 8'd201, 8'd199, 2, 1, 3, 1, 8'd199, "after_rst_s2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/abc.md
# abc

Acquisition-and-reduce controller sitting between three 8-bit A/D converters and one downstream consumer. Each cycle it starts all three converters with a shared start-of-conversion pulse and waits for all three to finish. It then latches the unsigned minimum of the three samples and offers it to the consumer over a dav_/rfd handshake. Conversion rounds repeat indefinitely.

## Interface
- No parameters.
- clock  in  1  system clock, all state updates on rising edge
- reset_  in  1  asynchronous, active-low reset
- soc  out  1  start of conversion, shared by all three converters, active high
- eoc1, eoc2, eoc3  in  1 each  end of conversion from converter 1/2/3; high = idle/done, low = converting
- x1, x2, x3  in  8 each  conversion results; valid once the matching eocN has returned high
- dav_  out  1  data available to consumer, active low
- rfd  in  1  consumer ready-for-data, high = ready; consumer pulls low to acknowledge
- min  out  8  unsigned min(x1,x2,x3) of the current round, driven from a register

## Operation
- Registers: STAR (2-bit state), SOC, DAV_, MIN[7:0]; soc, dav_ and min are driven directly from SOC, DAV_ and MIN.
- Reset (reset_=0, asynchronous): SOC=0, DAV_=1, MIN=0, STAR=S3.
- S3 (wait consumer idle): if rfd==1 then SOC<=1, go S0; else stay.
- S0 (start): SOC=1 held; when eoc1==0 and eoc2==0 and eoc3==0 then SOC<=0, go S1; else stay.
- S1 (wait results): when eoc1==1 and eoc2==1 and eoc3==1 then MIN<=min(x1,x2,x3), DAV_<=0, go S2; else stay.
- S2 (offer): DAV_=0 held; when rfd==0 then DAV_<=1, go S3; else stay.
- Minimum: unsigned 8-bit compare, two-stage combinational (m=x1<x2?x1:x2; min=m<x3?m:x3). Ties give the shared value. Full range 0..255, no overflow possible.
- x inputs are sampled only on the S1 exit edge. Between rounds they are don't-care.
- MIN is stable from DAV_ falling until the next S1 exit, so it is valid throughout dav_=0.

## Timing
- soc rises 1 clock after reset release if rfd==1. It falls on the first edge where all three eoc are sampled low, so converters must hold eoc low until soc falls.
- Converters finish in any order and with any delay. Sampling happens on the first rising edge at which all three eoc read 1.
- dav_ falls on that same edge and min updates on that edge, with zero extra latency.
- dav_ rises on the first edge with rfd==0.
- soc rises again on the first edge with rfd==1 after dav_ rose. This completes the 4-phase handshake; there is no overlap between consecutive rounds.
- Asynchronous reset mid-round drops soc, raises dav_, clears min, and restarts at S3 regardless of the eoc/rfd levels.
- Simultaneous events: all eoc rising on one edge is the normal sampling case. A partial eoc=0 in S0 keeps waiting.

## Test plan
- Reset with rfd=1 and all eoc=1: soc=0, dav_=1, min=0 during reset; soc=1 one clock after release.
- Converters delay 1/2/3 clocks with x1=10, x2=20, x3=30: dav_ falls only after eoc3 returns high, with min=10. Consumer drops rfd, dav_ rises, rfd returns high, and soc rises again.
- Rotated values (20,30,10), (30,10,20) and 16 consecutive rounds with base 10..25 and multiples ×2/×3 shuffled: min equals the base value every round.
- Edge values: (0,255,128) gives min=0; (255,255,255) gives min=255; ties (7,7,9) give min=7.
- Consumer holds rfd=1 for 10 clocks after dav_ falls: dav_ stays 0 and min stays stable, and soc stays 0.
- Reset asserted in S1 and again in S2: outputs return to reset values immediately, and the next round completes correctly.
